// File: rtl/axis_sched_pkg.sv
// Shared types and reset constants for the axis_m packet scheduler.
package axis_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONFIG = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } sched_state_t;

  // Round-robin pointer starts at requester 0; beat counter starts empty.
  localparam int RR_PTR_RST = 0;
  localparam int CNT_RST    = 0;

endpackage

// File: rtl/axis_m_sched_if.sv
// Requester, axis_m and status signals of the scheduler, bundled as one interface.
interface axis_m_sched_if #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 32,
  parameter int LEN_WIDTH = 10
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ*LEN_WIDTH-1:0] req_len;
  logic [N_REQ-1:0]           req_ack;
  logic [N_REQ-1:0]           src_ready;
  logic [N_REQ-1:0]           src_valid;
  logic [N_REQ*WIDTH-1:0]     src_data;
  logic                       cfg_valid;
  logic [LEN_WIDTH-1:0]       cfg_len;
  logic                       axm_ready;
  logic                       axm_valid;
  logic [WIDTH-1:0]           axm_data;
  logic                       pkt_done;
  logic [IDW-1:0]             grant_id;
  logic                       busy;
  logic                       err_zero_len;

  // Scheduler side
  modport master (
    input  req_valid, req_len, src_valid, src_data, axm_ready, pkt_done,
    output req_ack, src_ready, cfg_valid, cfg_len, axm_valid, axm_data,
           grant_id, busy, err_zero_len
  );

  // Requester FIFOs / axis_m side
  modport slave (
    output req_valid, req_len, src_valid, src_data, axm_ready, pkt_done,
    input  req_ack, src_ready, cfg_valid, cfg_len, axm_valid, axm_data,
           grant_id, busy, err_zero_len
  );

endinterface

// File: rtl/axis_m_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]                      req,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
  output logic [N-1:0]                      gnt,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_id,
  output logic                              any
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Scan from ptr upward; the first hit wins and masks the rest.
  always_comb begin
    logic [IW-1:0] idx;
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int off = 0; off < N; off++) begin
      idx = IW'((int'(ptr) + off) % N);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/axis_m_sched.sv
// Round-robin packet scheduler feeding one axis_m stream master from N requesters.
module axis_m_sched
  import axis_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 32,
  parameter int LEN_WIDTH = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  axis_m_sched_if.master bus
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_t         state, state_nxt;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       gid;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] cnt;
  logic                 done_seen;

  logic [N_REQ-1:0]     arb_gnt;
  logic [IDW-1:0]       arb_id;
  logic                 arb_any;
  logic [LEN_WIDTH-1:0] cand_len;
  logic                 grant_now;
  logic                 push;
  logic                 last_push;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  assign cand_len  = bus.req_len[int'(arb_id)*LEN_WIDTH +: LEN_WIDTH];
  assign grant_now = (state == IDLE) && arb_any;
  assign push      = (state == STREAM) && bus.src_valid[gid] && bus.axm_ready;
  assign last_push = push && (cnt == len_q - 1'b1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: zero-length grants stay in IDLE; DRAIN leaves on a live or remembered tlast
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_now && (cand_len != '0)) state_nxt = CONFIG;
      CONFIG:  state_nxt = STREAM;
      STREAM:  if (last_push) state_nxt = DRAIN;
      DRAIN:   if (bus.pkt_done || done_seen) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant owner, round-robin pointer, beat counter and early-tlast flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= IDW'(RR_PTR_RST);
      gid       <= '0;
      cnt       <= LEN_WIDTH'(CNT_RST);
      done_seen <= 1'b0;
    end else begin
      if (grant_now) begin
        gid    <= arb_id;
        rr_ptr <= (int'(arb_id) == N_REQ - 1) ? '0 : arb_id + 1'b1;
        cnt    <= LEN_WIDTH'(CNT_RST);
      end else if (push) begin
        cnt <= cnt + 1'b1;
      end
      // tlast seen while still streaming lets DRAIN exit on its first cycle
      if (state == STREAM)     done_seen <= done_seen || bus.pkt_done;
      else if (state != DRAIN) done_seen <= 1'b0;
    end
  end

  // Descriptor length, captured only on the grant cycle
  always_ff @(posedge clk) begin
    if (grant_now) len_q <= cand_len;
  end

  // Outputs; IDLE pulses are gated by rst_n so every output is 0 while in reset
  always_comb begin
    bus.req_ack      = '0;
    bus.err_zero_len = 1'b0;
    bus.cfg_valid    = 1'b0;
    bus.cfg_len      = '0;
    bus.src_ready    = '0;
    bus.axm_valid    = 1'b0;
    bus.axm_data     = '0;
    case (state)
      IDLE: begin
        if (grant_now && rst_n) begin
          bus.req_ack      = arb_gnt;
          bus.err_zero_len = (cand_len == '0);
        end
      end
      CONFIG: begin
        bus.cfg_valid = 1'b1;
        bus.cfg_len   = len_q;
      end
      STREAM: begin
        bus.src_ready[gid] = bus.axm_ready;
        bus.axm_valid      = push;
        bus.axm_data       = bus.src_data[int'(gid)*WIDTH +: WIDTH];
      end
      default: ;
    endcase
  end

  assign bus.grant_id = gid;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_axis_m_sched.sv
// Bench for axis_m_sched with a small behavioural axis_m and requester FIFOs.
module tb_axis_m_sched;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int LW = 10;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  axis_m_sched_if #(.N_REQ(N), .WIDTH(W), .LEN_WIDTH(LW)) bus ();

  axis_m_sched #(.N_REQ(N), .WIDTH(W), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural axis_m: takes a length, accepts that many beats, re-emits them with tlast
  logic          tready;
  logic          tv, tl, ax_active;
  logic [W-1:0]  td;
  logic [LW-1:0] ax_rem;

  assign bus.axm_ready = ax_active && (ax_rem != '0) && (!tv || tready);
  assign bus.pkt_done  = tv && tready && tl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tv <= 1'b0; tl <= 1'b0; td <= '0; ax_active <= 1'b0; ax_rem <= '0;
    end else begin
      if (bus.cfg_valid) begin
        ax_active <= 1'b1;
        ax_rem    <= bus.cfg_len;
      end
      if (tv && tready) tv <= 1'b0;
      if (tv && tready && tl) ax_active <= 1'b0;
      if (bus.axm_valid && bus.axm_ready) begin
        tv     <= 1'b1;
        td     <= bus.axm_data;
        tl     <= (ax_rem == LW'(1));
        ax_rem <= ax_rem - LW'(1);
      end
    end
  end

  logic [W-1:0] prod_q [N][$];
  exp_t         exp_q[$];
  logic [1:0]   gq[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;
  int pop_cnt, pkt_cnt, cfg_cnt, err_cnt, last_cnt, first_pop, ack_cyc, cfg_edge;
  int ack_cnt [N];
  logic [LW-1:0] cfg_len_seen;
  logic gap = 1'b0;
  logic rand_ready = 1'b0;
  int t0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    pop_cnt = 0; pkt_cnt = 0; cfg_cnt = 0; err_cnt = 0; last_cnt = 0;
    first_pop = -1; ack_cyc = -1; cfg_edge = -1; cfg_len_seen = '0;
    gq.delete();
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      if (prod_q[i].size() > 0) begin
        bus.src_data[i*W +: W] = prod_q[i][0];
        bus.src_valid[i]       = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      end else begin
        bus.src_data[i*W +: W] = '0;
        bus.src_valid[i]       = 1'b0;
      end
    end
    tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // Fill requester i's FIFO and queue the beats axis_m must emit for it
  task automatic load(input int i, input int n, input logic [W-1:0] base);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      prod_q[i].push_back(base + W'(k));
      e.d = base + W'(k);
      e.l = (k == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic post(input int i, input int len);
    bus.req_len[i*LW +: LW] = LW'(len);
    bus.req_valid[i]        = 1'b1;
  endtask

  // One clock: observe at negedge, then update stimulus just after the posedge
  task automatic cyc();
    logic [N-1:0] popm, ackm;
    exp_t e;
    @(negedge clk);
    popm = bus.src_valid & bus.src_ready;
    ackm = bus.req_ack;
    for (int i = 0; i < N; i++) begin
      if (popm[i]) begin
        if (first_pop < 0) first_pop = cyc_n;
        pop_cnt++;
      end
      if (ackm[i]) begin
        if (ack_cyc < 0) ack_cyc = cyc_n;
        ack_cnt[i]++;
      end
    end
    if (bus.err_zero_len) err_cnt++;
    if (bus.cfg_valid) begin
      cfg_cnt++;
      cfg_len_seen = bus.cfg_len;
      cfg_edge     = cyc_n + 1;
      gq.push_back(bus.grant_id);
      chk("cfg_while_axm_busy", {63'd0, ax_active}, 64'd0);
    end
    if (tv && tready) begin
      if (tl) last_cnt++;
      if (exp_q.size() == 0) begin
        chk("beat_unexpected", {63'd0, tv}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", {32'd0, td}, {32'd0, e.d});
        chk("beat_last", {63'd0, tl}, {63'd0, e.l});
      end
    end
    if (bus.pkt_done) pkt_cnt++;
    @(posedge clk);
    cyc_n++;
    #1;
    for (int i = 0; i < N; i++) begin
      if (popm[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
      if (ackm[i]) bus.req_valid[i] = 1'b0;
    end
    refresh();
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while ((bus.req_valid != '0 || bus.busy || exp_q.size() != 0 || tv) && n < budget) begin
      cyc();
      n++;
    end
    vectors++;
    assert (n < budget) else begin
      miscompares++;
      $error("FAIL %s_timeout: observed %0d cycles expected fewer than %0d", tag, n, budget);
    end
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_busy"},      {63'd0, bus.busy},          64'd0);
    chk({tag, "_cfg_valid"}, {63'd0, bus.cfg_valid},     64'd0);
    chk({tag, "_cfg_len"},   {54'd0, bus.cfg_len},       64'd0);
    chk({tag, "_req_ack"},   {60'd0, bus.req_ack},       64'd0);
    chk({tag, "_src_ready"}, {60'd0, bus.src_ready},     64'd0);
    chk({tag, "_axm_valid"}, {63'd0, bus.axm_valid},     64'd0);
    chk({tag, "_axm_data"},  {32'd0, bus.axm_data},      64'd0);
    chk({tag, "_grant_id"},  {62'd0, bus.grant_id},      64'd0);
    chk({tag, "_err"},       {63'd0, bus.err_zero_len},  64'd0);
  endtask

  task automatic flush_and_release();
    for (int i = 0; i < N; i++) prod_q[i].delete();
    exp_q.delete();
    bus.req_valid = '0;
    refresh();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_len   = '0;
    bus.src_valid = '0;
    bus.src_data  = '0;
    tready        = 1'b1;
    clear_stats();
    #2 rst_n = 1'b0;
    #1 reset_outputs_zero("rst");
    flush_and_release();

    // 1: single 3-beat packet from requester 0
    clear_stats();
    load(0, 3, 32'hA000_0000);
    post(0, 3);
    refresh();
    t0 = cyc_n;
    wait_done(100, "t1");
    chk("t1_ack_cycle",  64'(ack_cyc - t0), 64'd0);
    chk("t1_req_to_cfg", 64'(cfg_edge - t0), 64'd2);
    chk("t1_first_pop",  64'(first_pop - t0), 64'd2);
    chk("t1_cfg_len",    {54'd0, cfg_len_seen}, 64'd3);
    chk("t1_cfg_cnt",    64'(cfg_cnt), 64'd1);
    chk("t1_pops",       64'(pop_cnt), 64'd3);
    chk("t1_pkts",       64'(pkt_cnt), 64'd1);
    chk("t1_ack0",       64'(ack_cnt[0]), 64'd1);
    chk("t1_busy_drop",  {63'd0, bus.busy}, 64'd0);

    // 2: all four requesters, one beat each, from a fresh pointer
    rst_n = 1'b0;
    flush_and_release();
    clear_stats();
    for (int i = 0; i < N; i++) begin
      load(i, 1, 32'hB000_0000 + W'(i * 16));
      post(i, 1);
    end
    refresh();
    wait_done(300, "t2");
    chk("t2_grants", 64'(gq.size()), 64'd4);
    for (int k = 0; k < N; k++) begin
      chk("t2_order", {62'd0, gq[k]}, 64'(k));
      chk("t2_ack_once", 64'(ack_cnt[k]), 64'd1);
    end
    chk("t2_pkts", 64'(pkt_cnt), 64'd4);

    // 3: grant 2, then requesters 1 and 3 -> 3 before 1
    clear_stats();
    load(2, 1, 32'hC200_0000);
    post(2, 1);
    refresh();
    wait_done(100, "t3a");
    chk("t3_first_grant", {62'd0, gq[0]}, 64'd2);
    clear_stats();
    load(3, 2, 32'hC300_0000);
    load(1, 2, 32'hC100_0000);
    post(3, 2);
    post(1, 2);
    refresh();
    wait_done(200, "t3b");
    chk("t3_wrap_first",  {62'd0, gq[0]}, 64'd3);
    chk("t3_wrap_second", {62'd0, gq[1]}, 64'd1);
    chk("t3_pkts", 64'(pkt_cnt), 64'd2);

    // Park the pointer at 0 via a grant to requester 3
    clear_stats();
    load(3, 1, 32'hC3F0_0000);
    post(3, 1);
    refresh();
    wait_done(100, "t4pre");

    // 4: zero-length descriptor from requester 1 is acked and dropped
    clear_stats();
    post(1, 0);
    refresh();
    wait_done(20, "t4");
    chk("t4_err_pulse", 64'(err_cnt), 64'd1);
    chk("t4_ack1",      64'(ack_cnt[1]), 64'd1);
    chk("t4_no_cfg",    64'(cfg_cnt), 64'd0);
    clear_stats();
    load(2, 1, 32'hD200_0000);
    load(0, 1, 32'hD000_0000);
    post(0, 1);
    post(2, 1);
    refresh();
    wait_done(100, "t4b");
    chk("t4_ptr_after_drop", {62'd0, gq[0]}, 64'd2);
    chk("t4_then_0",         {62'd0, gq[1]}, 64'd0);

    // 5: 8 beats with gapped source and random tready
    clear_stats();
    gap = 1'b1;
    rand_ready = 1'b1;
    load(0, 8, 32'hE000_0000);
    post(0, 8);
    refresh();
    wait_done(2000, "t5");
    chk("t5_pops",  64'(pop_cnt), 64'd8);
    chk("t5_pkts",  64'(pkt_cnt), 64'd1);
    chk("t5_tlast", 64'(last_cnt), 64'd1);
    gap = 1'b0;
    rand_ready = 1'b0;
    refresh();

    // 6: reset while streaming beat 4 of 8, then a clean 2-beat packet
    clear_stats();
    load(2, 8, 32'hF200_0000);
    post(2, 8);
    refresh();
    begin
      int n;
      n = 0;
      while (pop_cnt < 4 && n < 100) begin
        cyc();
        n++;
      end
      chk("t6_reach_beat4", 64'(pop_cnt), 64'd4);
    end
    chk("t6_busy_before", {63'd0, bus.busy}, 64'd1);
    chk("t6_gid_before",  {62'd0, bus.grant_id}, 64'd2);
    rst_n = 1'b0;
    #1 reset_outputs_zero("t6_rst");
    flush_and_release();
    clear_stats();
    load(2, 2, 32'hF2F0_0000);
    post(2, 2);
    refresh();
    wait_done(100, "t6b");
    chk("t6_cfg_len", {54'd0, cfg_len_seen}, 64'd2);
    chk("t6_pops",    64'(pop_cnt), 64'd2);
    chk("t6_pkts",    64'(pkt_cnt), 64'd1);
    chk("t6_grant",   {62'd0, gq[0]}, 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
